// File: rtl/cave_mem_pkg.sv
// cave_mem_pkg
//   Shared types and widths for the cave memory write path.
//   - state_t       : coalescer FSM states
//   - *_AW / *_W    : word/line address and data widths
//   - *_MASK_W      : byte-enable widths
//   - byte_mask_to_bits : expands a line byte mask to a per-bit mask
package cave_mem_pkg;

    localparam int LINE_AW     = 16;  // 64-bit line address width
    localparam int WORD_AW     = 17;  // 32-bit word address width
    localparam int WORD_W      = 32;
    localparam int LINE_W      = 64;
    localparam int WORD_MASK_W = 4;
    localparam int LINE_MASK_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    function automatic logic [LINE_W-1:0] byte_mask_to_bits(input logic [LINE_MASK_W-1:0] m);
        logic [LINE_W-1:0] r;
        for (int i = 0; i < LINE_MASK_W; i++) begin
            r[i*8 +: 8] = {8{m[i]}};
        end
        return r;
    endfunction

endpackage

// File: rtl/write_coalescer.sv
// write_coalescer
//   Merges 32-bit word writes into 64-bit line writes. A line is held in
//   PEND until both halves are fully written, a write to another line
//   arrives, or it sits idle for TIMEOUT-1 cycles; it is then issued.
//
// Ports
//   clock, reset        : clock, asynchronous active-low reset
//   io_in_*             : word write request channel (valid/ready)
//   io_mem_*            : registered 64-bit line write to memory
//   io_mem_waitReq      : memory stall, holds the write in ISSUE
//   io_busy             : a line is pending or being issued
//   dbg_state           : current FSM state (debug observation)
//
// Handshake: a word transfer happens on a rising clock edge where
// io_in_valid and io_in_ready are both 1. io_in_ready never depends on
// io_in_valid. On the memory side the write is presented while io_mem_wr
// is 1 and completes on an edge where io_mem_waitReq is 0.
module write_coalescer
    import cave_mem_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   io_in_ready,
    input  logic                   io_in_valid,
    input  logic [WORD_AW-1:0]     io_in_bits_addr,
    input  logic [WORD_W-1:0]      io_in_bits_din,
    input  logic [WORD_MASK_W-1:0] io_in_bits_mask,
    output logic                   io_mem_wr,
    output logic [LINE_AW-1:0]     io_mem_addr,
    output logic [LINE_W-1:0]      io_mem_din,
    output logic [LINE_MASK_W-1:0] io_mem_mask,
    input  logic                   io_mem_waitReq,
    output logic                   io_busy,
    output logic [1:0]             dbg_state
);

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t                 state;
    logic [LINE_AW-1:0]     line_addr;
    logic [LINE_W-1:0]      line_data;
    logic [LINE_MASK_W-1:0] line_mask;
    logic [7:0]             timer;

    logic [LINE_AW-1:0]     in_line;
    logic [LINE_W-1:0]      lane_data;
    logic [LINE_MASK_W-1:0] lane_mask;
    logic [LINE_W-1:0]      lane_bits;
    logic [LINE_W-1:0]      merged_data;
    logic [LINE_MASK_W-1:0] merged_mask;
    logic [LINE_W-1:0]      issue_data;
    logic [LINE_MASK_W-1:0] issue_mask;
    logic [7:0]             timer_inc;
    logic                   fire;
    logic                   go_issue;

    assign in_line   = io_in_bits_addr[WORD_AW-1:1];
    assign io_busy   = (state != ST_IDLE);
    assign dbg_state = state;
    assign timer_inc = timer + 8'd1;
    assign fire      = io_in_valid && io_in_ready;

    // Place the incoming word in its half of the line; unmasked bytes are
    // forced to zero so they never leak into the issued data.
    always_comb begin
        lane_data = io_in_bits_addr[0] ? {io_in_bits_din, {WORD_W{1'b0}}}
                                       : {{WORD_W{1'b0}}, io_in_bits_din};
        lane_mask = io_in_bits_addr[0] ? {io_in_bits_mask, {WORD_MASK_W{1'b0}}}
                                       : {{WORD_MASK_W{1'b0}}, io_in_bits_mask};
        lane_bits   = byte_mask_to_bits(lane_mask);
        merged_data = (line_data & ~lane_bits) | (lane_data & lane_bits);
        merged_mask = line_mask | lane_mask;
    end

    always_comb begin
        io_in_ready = 1'b0;
        case (state)
            ST_IDLE:  io_in_ready = 1'b1;
            ST_PEND:  io_in_ready = (in_line == line_addr);
            default:  io_in_ready = 1'b0;
        endcase
    end

    // In PEND a same-line write completing the line is issued with the
    // merged contents; other exits issue the buffer as it stands.
    always_comb begin
        issue_data = line_data;
        issue_mask = line_mask;
        go_issue   = 1'b0;
        if (state == ST_PEND) begin
            if (fire) begin
                issue_data = merged_data;
                issue_mask = merged_mask;
                go_issue   = (merged_mask == 8'hFF);
            end else begin
                go_issue = io_in_valid || (timer_inc == TIMER_LAST);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            line_addr   <= '0;
            line_data   <= '0;
            line_mask   <= '0;
            timer       <= '0;
            io_mem_wr   <= 1'b0;
            io_mem_addr <= '0;
            io_mem_din  <= '0;
            io_mem_mask <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    io_mem_wr <= 1'b0;
                    if (fire) begin
                        line_addr <= in_line;
                        line_data <= lane_data & lane_bits;
                        line_mask <= lane_mask;
                        timer     <= '0;
                        state     <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (fire) begin
                        line_data <= merged_data;
                        line_mask <= merged_mask;
                        timer     <= '0;
                    end else begin
                        timer <= timer_inc;
                    end
                    if (go_issue) begin
                        state       <= ST_ISSUE;
                        io_mem_wr   <= 1'b1;
                        io_mem_addr <= line_addr;
                        io_mem_din  <= issue_data;
                        io_mem_mask <= issue_mask;
                    end
                end
                ST_ISSUE: begin
                    if (!io_mem_waitReq) begin
                        state     <= ST_IDLE;
                        io_mem_wr <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    io_mem_wr <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/write_coalescer.md
WRITE_COALESCER -- requirements
Module: write_coalescer

Interface
REQ-001 Parameter: TIMEOUT, default 8, idle cycles a half-filled line is held before being issued alone (legal range 2..255).
REQ-002 Port: clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: io_in_ready  output  1  coalescer accepts the current request this cycle.
REQ-005 Port: io_in_valid  input  1  write request present.
REQ-006 Port: io_in_bits_addr  input  17  32-bit word address.
REQ-007 Port: io_in_bits_din  input  32  write data.
REQ-008 Port: io_in_bits_mask  input  4  byte enables.
REQ-009 Port: io_mem_wr  output  1  64-bit memory write request.
REQ-010 Port: io_mem_addr  output  16  64-bit line address.
REQ-011 Port: io_mem_din  output  64  line data.
REQ-012 Port: io_mem_mask  output  8  line byte enables.
REQ-013 Port: io_mem_waitReq  input  1  memory stalls the current write.
REQ-014 Port: io_busy  output  1  a line is pending or being issued (state != IDLE).

Function
REQ-015 An input transfer SHALL occur on a rising edge where io_in_valid and io_in_ready are both 1.
REQ-016 Line address SHALL be io_in_bits_addr[16:1]; addr[0]=0 maps to data[31:0]/mask[3:0], and addr[0]=1 to data[63:32]/mask[7:4].
REQ-017 States SHALL be IDLE, PEND, ISSUE.
REQ-018 IDLE: io_in_ready=1; a transfer SHALL clear the line buffer, load the word into its lane, latch the line address, clear the timer, and enter PEND.
REQ-019 PEND: io_in_ready SHALL be 1 only when io_in_bits_addr[16:1] equals the latched line, combinationally from the address.
REQ-020 PEND same-line transfer: bytes with mask set SHALL overwrite the buffer (later wins), masks OR, timer cleared; if the merged mask is 8'hFF the next state SHALL be ISSUE, otherwise PEND.
REQ-021 PEND with io_in_valid=1 and a different line: no transfer; next state SHALL be ISSUE.
REQ-022 PEND with no transfer: timer increments; when it reaches TIMEOUT-1 the next state SHALL be ISSUE.
REQ-023 ISSUE: io_in_ready=0; io_mem_wr=1 with buffered addr/din/mask stable; on an edge with io_mem_waitReq=0 the next state SHALL be IDLE.
REQ-024 Outputs io_mem_* SHALL be registered; io_mem_wr SHALL rise the cycle after the edge that enters ISSUE.
REQ-025 Bytes with mask clear SHALL be 0 in io_mem_din.
REQ-026 Mask-zero input writes SHALL be accepted normally and contribute no bytes.
REQ-027 io_mem_wr SHALL be 0 in IDLE and PEND.

Reset
REQ-028 While reset=0: state IDLE, io_mem_wr=0, io_mem_addr=0, io_mem_din=0, io_mem_mask=0, timer=0, io_busy=0.
REQ-029 Reset asserted mid-PEND or mid-ISSUE SHALL discard the pending line without a memory write.

Structure
REQ-030 State enum, line/word widths (16/17/32/64) and the mask width SHALL live in shared package cave_mem_pkg.
REQ-031 The block SHALL be a single module; no sub-module is required.

Verification
REQ-032 Two valid writes at addr 0x00010 (din 0x11111111, mask F) and 0x00011 (din 0x22222222, mask F) back-to-back, waitReq=0 -> one write: io_mem_addr 0x0008, din 0x2222222211111111, mask FF, io_mem_wr high one cycle.
REQ-033 Single write at addr 0x00021, din 0xAABBCCDD, mask 3, no further input -> after TIMEOUT=8 cycles, write addr 0x0010, din 0x0000CCDD00000000, mask 0x30.
REQ-034 Write at 0x00004 then write at 0x00008 -> second not accepted (ready 0); first issued alone as addr 0x0002, mask 0x0F; second then accepted from IDLE.
REQ-035 Pair completing a line while waitReq=1 for 5 cycles -> io_mem_wr and outputs held stable 5 cycles, ready 0, IDLE after waitReq falls.
REQ-036 Write 0x00000 din 0x000000FF mask 1, then 0x00000 din 0x0000EE00 mask 2 -> merged mask 0x03, din[15:0]=0xEEFF, still PEND.
REQ-037 Reset pulse while in PEND -> no io_mem_wr ever, io_busy 0, next write starts a fresh line.
